// File: rtl/reg_write_bridge.sv
// reg_write_bridge
// Receives 8-bit register-write frames over a mode-0 SPI-style link, queues
// them in a small FIFO and replays each one as wr_addr/wr_data with a long
// wr_strobe pulse. The pulse is long enough for a slow, scaled-clock consumer
// to sample it. Frame layout: bits[7:5] = register address, bits[4:0] = data.

module reg_write_bridge #(
    parameter int STROBE_CYCLES = 100,
    parameter int GAP_CYCLES    = 100,
    parameter int FIFO_DEPTH    = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       wr_strobe,
    output logic [2:0] wr_addr,
    output logic [4:0] wr_data,
    output logic       busy,
    output logic       overflow
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PW      = AW + 1;
    localparam int CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic                   sck_prev_q;

    logic sck_s;
    logic mosi_s;
    logic csn_s;
    logic sck_rise_s;

    // Bring the asynchronous SPI pins into the clk domain, all at the same depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= {SYNC_STAGES{1'b0}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            csn_sync_q  <= {SYNC_STAGES{1'b1}};
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign csn_s      = csn_sync_q[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_prev_q;

    // ------------------------------------------------------------------
    // Deserializer
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt_q;
    logic [2:0] bit_cnt_d;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [7:0] frame_s;
    logic       push_s;

    // The byte being completed by the current bit; this is what gets pushed.
    assign frame_s = {shift_q[6:0], mosi_s};

    // Shift on each synced sck rise; a deselect or ena=0 discards any partial frame.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push_s    = 1'b0;
        if (!ena || csn_s) begin
            bit_cnt_d = 3'd0;
        end else if (sck_rise_s) begin
            shift_d   = frame_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                push_s = 1'b1;
            end else begin
                push_s = 1'b0;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Deserializer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          overflow_q;

    logic       empty_s;
    logic       full_s;
    logic       pop_s;
    logic       push_ok_s;
    logic [7:0] head_s;

    state_e     state_q;

    // Extra pointer bit tells full from empty when the index bits match.
    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head_s    = mem_q[rd_ptr_q[AW-1:0]];
    assign pop_s     = (state_q == ST_IDLE) & ena & ~empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok_s = push_s & (~full_s | pop_s);

    // FIFO storage, pointers and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= frame_s;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (push_s && full_s && !pop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FSM: IDLE -> HOLD (strobe high) -> GAP (strobe low) -> IDLE
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q;
    logic          strobe_q;
    logic [2:0]    addr_q;
    logic [4:0]    data_q;

    // Replays one queued frame per pass; a started HOLD/GAP always runs to completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CW{1'b0}};
            strobe_q <= 1'b0;
            addr_q   <= 3'd0;
            data_q   <= 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        addr_q   <= head_s[7:5];
                        data_q   <= head_s[4:0];
                        strobe_q <= 1'b1;
                        cnt_q    <= {CW{1'b0}};
                        state_q  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        strobe_q <= 1'b0;
                        cnt_q    <= {CW{1'b0}};
                        state_q  <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= {CW{1'b0}};
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    strobe_q <= 1'b0;
                    cnt_q    <= {CW{1'b0}};
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_strobe = strobe_q;
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign overflow  = overflow_q;
    // Taken straight from registered state so it adds no latency.
    assign busy      = (state_q != ST_IDLE) | ~empty_s;

endmodule

// File: tb/tb_reg_write_bridge.sv
// Directed testbench for reg_write_bridge: drives SPI frames and checks the
// replayed register writes against hand-computed values.

module tb_reg_write_bridge;

    localparam int HALF = 2;   // sck half-period in clk cycles (sck = clk/4)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic       busy;
    logic       overflow;

    int n_assert = 0;
    int n_fail   = 0;

    reg_write_bridge #(
        .STROBE_CYCLES(100),
        .GAP_CYCLES   (100),
        .FIFO_DEPTH   (4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_cs_n (spi_cs_n),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Write monitor: records each strobe's rise cycle, addr/data and width.
    int         cyc = 0;
    int         rise_q[$];
    int         width_q[$];
    logic [2:0] addr_q[$];
    logic [4:0] data_q[$];
    int         hi_cnt = 0;
    int         stab_err = 0;
    logic       prev_strobe = 1'b0;
    logic [2:0] last_addr = 3'd0;
    logic [4:0] last_data = 5'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_strobe && !prev_strobe) begin
            rise_q.push_back(cyc);
            addr_q.push_back(wr_addr);
            data_q.push_back(wr_data);
            hi_cnt = 1;
        end else if (wr_strobe) begin
            hi_cnt++;
            if (wr_addr != last_addr || wr_data != last_data) stab_err++;
        end
        if (!wr_strobe && prev_strobe) width_q.push_back(hi_cnt);
        prev_strobe = wr_strobe;
        last_addr   = wr_addr;
        last_data   = wr_data;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        rise_q.delete();
        width_q.delete();
        addr_q.delete();
        data_q.delete();
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        tick(HALF);
        spi_sck = 1'b1;
        tick(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_end();
        spi_cs_n = 1'b1;
        tick(4);
    endtask

    task automatic wait_strobe(input string tag, input int budget);
        int k = 0;
        while (!wr_strobe && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, wr_strobe, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((busy || wr_strobe) && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, busy, 0);
    endtask

    task automatic check_wr(input string tag, input int i, input logic [2:0] a,
                            input logic [4:0] d);
        if (i < addr_q.size()) begin
            check({tag, "_addr"}, addr_q[i], a);
            check({tag, "_data"}, data_q[i], d);
        end else begin
            check({tag, "_missing"}, addr_q.size(), i + 1);
        end
        if (i < width_q.size()) begin
            check({tag, "_width"}, width_q[i], 100);
        end else begin
            check({tag, "_nowidth"}, width_q.size(), i + 1);
        end
    endtask

    initial begin
        // ---------------- Test 1: reset state, single frame 0xA5 ----------
        tick(5);
        check("rst_strobe", wr_strobe, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        tick(5);
        cs_begin();
        spi_byte(8'hA5);
        cs_end();
        wait_strobe("t1_strobe_timeout", 200);
        check("t1_busy_hold", busy, 1);
        wait_idle("t1_idle_timeout", 1000);
        check("t1_count", rise_q.size(), 1);
        check_wr("t1_w0", 0, 3'd5, 5'd5);
        check("t1_ovf", overflow, 0);

        // ---------------- Test 2: three frames in one cs_n period ----------
        clear_log();
        cs_begin();
        spi_byte(8'h21);
        spi_byte(8'h42);
        spi_byte(8'h63);
        cs_end();
        wait_idle("t2_idle_timeout", 3000);
        check("t2_count", rise_q.size(), 3);
        check_wr("t2_w0", 0, 3'd1, 5'd1);
        check_wr("t2_w1", 1, 3'd2, 5'd2);
        check_wr("t2_w2", 2, 3'd3, 5'd3);
        if (rise_q.size() >= 3) begin
            check("t2_space01", rise_q[1] - rise_q[0], 201);
            check("t2_space12", rise_q[2] - rise_q[1], 201);
        end else begin
            check("t2_space_missing", rise_q.size(), 3);
        end
        check("t2_ovf", overflow, 0);

        // ---------------- Test 3: overflow, 6 frames, 5 accepted ----------
        clear_log();
        cs_begin();
        for (int i = 1; i <= 6; i++) spi_byte(8'h80 | 8'(i));
        cs_end();
        check("t3_ovf", overflow, 1);
        wait_idle("t3_idle_timeout", 3000);
        check("t3_count", rise_q.size(), 5);
        for (int i = 0; i < 5; i++) check_wr("t3_w", i, 3'd4, 5'(i + 1));

        // ---------------- Test 4: aborted partial frame, then 0x1F ----------
        clear_log();
        cs_begin();
        spi_bit(1'b1);
        spi_bit(1'b0);
        spi_bit(1'b1);
        spi_bit(1'b1);
        spi_bit(1'b0);
        cs_end();
        cs_begin();
        spi_byte(8'h1F);
        cs_end();
        wait_idle("t4_idle_timeout", 1000);
        check("t4_count", rise_q.size(), 1);
        check_wr("t4_w0", 0, 3'd0, 5'd31);
        check("t4_ovf_sticky", overflow, 1);

        // ---------------- Test 5: reset mid-HOLD ----------
        clear_log();
        cs_begin();
        spi_byte(8'h4A);
        spi_byte(8'h4B);
        cs_end();
        wait_strobe("t5_strobe_timeout", 200);
        tick(20);
        check("t5_busy_pre", busy, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_strobe", wr_strobe, 0);
        check("t5_addr", wr_addr, 0);
        check("t5_data", wr_data, 0);
        check("t5_busy", busy, 0);
        check("t5_ovf", overflow, 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        clear_log();
        tick(400);
        check("t5_no_replay", rise_q.size(), 0);
        cs_begin();
        spi_byte(8'hE7);
        cs_end();
        wait_idle("t5_idle_timeout", 1000);
        check("t5_count", rise_q.size(), 1);
        check_wr("t5_w0", 0, 3'd7, 5'd7);

        // ---------------- Test 6: ena=0 during HOLD ----------
        clear_log();
        cs_begin();
        spi_byte(8'h2C);
        spi_byte(8'hD3);
        cs_end();
        wait_strobe("t6_strobe_timeout", 200);
        tick(5);
        ena = 1'b0;
        cs_begin();
        spi_byte(8'hFF);
        cs_end();
        tick(400);
        check("t6_count_held", rise_q.size(), 1);
        check_wr("t6_w0", 0, 3'd1, 5'd12);
        check("t6_busy_held", busy, 1);
        check("t6_strobe_held", wr_strobe, 0);
        ena = 1'b1;
        wait_idle("t6_idle_timeout", 1000);
        check("t6_count", rise_q.size(), 2);
        check_wr("t6_w1", 1, 3'd6, 5'd19);
        check("t6_addr_hold", wr_addr, 6);
        check("t6_data_hold", wr_data, 19);

        check("stable_during_strobe", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
